// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the IF/DOF/EX/WB core: RAW stall, taken-branch squash, external freeze.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int R0_ZERO   = 1,
  parameter int RF_WT     = 0,
  parameter int MAX_STALL = 15,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] aa,
  input  logic [REG_AW-1:0] ba,
  input  logic              use_a,
  input  logic              use_b,
  input  logic [REG_AW-1:0] ex_da,
  input  logic              ex_rw,
  input  logic [REG_AW-1:0] wb_da,
  input  logic              wb_rw,
  input  logic              br_taken,
  input  logic              ext_hold,
  input  logic              perf_clr,
  output logic              pc_en,
  output logic              ifd_en,
  output logic              ifd_flush,
  output logic              dex_bubble,
  output logic              back_en,
  output logic [1:0]        state,
  output logic              hazard_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HOLD = 2'd3} state_t;

  localparam int            TW   = $clog2(MAX_STALL + 2);
  localparam logic [TW-1:0] TMAX = TW'(MAX_STALL + 1);

  state_t        cur, nxt;
  logic [TW-1:0] tmr, tmr_inc;
  logic          haz_ex, haz_wb, haz;
  logic          do_hold, do_flush, do_stall;

  // In FLUSH the DOF latch holds a NOP, so its register fields are meaningless.
  always_comb begin
    haz_ex = ex_rw && !((R0_ZERO != 0) && (ex_da == '0)) &&
             ((use_a && (aa == ex_da)) || (use_b && (ba == ex_da)));
    haz_wb = (RF_WT == 0) && wb_rw && !((R0_ZERO != 0) && (wb_da == '0)) &&
             ((use_a && (aa == wb_da)) || (use_b && (ba == wb_da)));
    haz    = (haz_ex || haz_wb) && (cur != FLUSH);
  end

  always_comb begin
    do_hold  = ext_hold;
    do_flush = !ext_hold && br_taken && (cur != FLUSH);
    do_stall = !ext_hold && !do_flush && haz;
    if (do_hold)       nxt = HOLD;
    else if (do_flush) nxt = FLUSH;
    else if (do_stall) nxt = STALL;
    else               nxt = RUN;
  end

  always_comb begin
    pc_en      = 1'b1;
    ifd_en     = 1'b1;
    ifd_flush  = 1'b0;
    dex_bubble = 1'b0;
    back_en    = 1'b1;
    if (!rst) begin
      // Fill the pipe with NOPs while reset is held.
      pc_en      = 1'b0;
      ifd_en     = 1'b0;
      ifd_flush  = 1'b1;
      dex_bubble = 1'b1;
    end else if (do_hold) begin
      pc_en   = 1'b0;
      ifd_en  = 1'b0;
      back_en = 1'b0;
    end else if (do_flush) begin
      ifd_flush  = 1'b1;
      dex_bubble = 1'b1;
    end else if (do_stall) begin
      pc_en      = 1'b0;
      ifd_en     = 1'b0;
      dex_bubble = 1'b1;
    end
  end

  assign tmr_inc = (tmr == TMAX) ? TMAX : tmr + TW'(1);

  // HOLD freezes the stall timer rather than clearing it.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= RUN;
      tmr        <= '0;
      hazard_err <= 1'b0;
    end else begin
      cur <= nxt;
      if (do_stall) begin
        tmr <= tmr_inc;
        if (tmr_inc == TMAX) hazard_err <= 1'b1;
      end else if (!do_hold) begin
        tmr <= '0;
      end
    end
  end

  assign state = cur;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (do_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = perf_clr;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the 4-stage IF/DOF/EX/WB RISC core. It detects read-after-write register hazards between DOF and the later stages and stalls the front end. It squashes wrong-path instructions when a branch or jump resolves taken in EX. It also freezes the whole pipeline on an external hold request. Its enables, flushes and bubbles drive the pipeline latch bank in the CPU top level.

Parameters:
- REG_AW, 5, register address width (matches the AA/BA/DA fields).
- R0_ZERO, 1, when 1, register address 0 never creates a hazard.
- RF_WT, 0, when 1, the register file writes through in the same cycle, so WB-stage producers are ignored.
- MAX_STALL, 15, consecutive stall cycles tolerated before hazard_err sets.
- CNT_W, 16, performance counter width.

Ports:
- clk, in, 1, pipeline clock. All state updates on the falling edge, the same edge as the pipeline latches.
- rst, in, 1, asynchronous, active-low reset.
- aa, in, REG_AW, DOF source A address.
- ba, in, REG_AW, DOF source B address.
- use_a, in, 1, DOF instruction reads A.
- use_b, in, 1, DOF instruction reads B.
- ex_da, in, REG_AW, EX-stage destination.
- ex_rw, in, 1, EX-stage register write.
- wb_da, in, REG_AW, WB-stage destination.
- wb_rw, in, 1, WB-stage register write.
- br_taken, in, 1, EX-stage branch or jump resolved taken (from BS/PS/Z).
- ext_hold, in, 1, memory or debug request to freeze everything.
- perf_clr, in, 1, synchronous clear of the counters (PERF_CNT_EN only).
- pc_en, out, 1, PC register load enable.
- ifd_en, out, 1, IF/DOF latch enable.
- ifd_flush, out, 1, load NOP (all-zero IR) into the IF/DOF latch.
- dex_bubble, out, 1, clear RW, MW, PS, BS and MD in the DOF/EX latch.
- back_en, out, 1, EX/WB latch and DOF/EX latch enable.
- state, out, 2, current FSM state.
- hazard_err, out, 1, sticky stall-timeout flag.
- stall_cnt, out, CNT_W, total stall cycles (PERF_CNT_EN only).
- flush_cnt, out, CNT_W, total taken-branch flushes (PERF_CNT_EN only).

Behaviour:
- States:
  - RUN = 0
  - STALL = 1
  - FLUSH = 2
  - HOLD = 3
- Hazard definition:
  - haz_ex = ex_rw AND dest≠0 (if R0_ZERO) AND ((use_a AND aa==ex_da) OR (use_b AND ba==ex_da)).
  - haz_wb is the same test against wb_da/wb_rw, forced 0 when RF_WT=1.
  - haz = haz_ex OR haz_wb.
- Priority per cycle: ext_hold > br_taken > haz > normal.
- Outputs are combinational from the current state and inputs, effective at the next falling edge:
  - ext_hold=1: pc_en=ifd_en=back_en=0, ifd_flush=dex_bubble=0. Next state HOLD. On release, return to RUN and re-evaluate all conditions.
  - br_taken=1: pc_en=1 (the PC loads the branch target), ifd_flush=1, dex_bubble=1, ifd_en=1, back_en=1. Next state FLUSH. This squashes the 2 wrong-path instructions and overrides any concurrent haz.
  - haz=1 (no branch): pc_en=0, ifd_en=0, dex_bubble=1, back_en=1. Next state STALL.
  - Otherwise: pc_en=ifd_en=back_en=1, ifd_flush=dex_bubble=0. Next state RUN.
- FLUSH lasts exactly 1 cycle. In that cycle DOF holds a NOP, so hazard detection is masked and outputs are the normal values. Next state RUN, or HOLD if ext_hold=1.
- STALL remains while haz=1 and moves to RUN when it clears. A taken branch while in STALL goes to FLUSH.
- Stall timer:
  - Counts consecutive STALL cycles, saturating at MAX_STALL+1, and clears on leaving STALL.
  - Reaching MAX_STALL+1 sets hazard_err. hazard_err clears only on reset.
- HOLD does not advance the stall timer or the counters.
- Reset (rst=0, asynchronous):
  - state=RUN, hazard_err=0, counters=0.
  - While asserted, outputs are forced to pc_en=0, ifd_en=0, back_en=1, ifd_flush=1, dex_bubble=1, so the pipeline fills with NOPs.
  - Deassertion mid-operation resumes in RUN with no residual stall.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle that haz causes a stall.
  - flush_cnt increments on each br_taken acceptance.
  - Both saturate at all-ones and clear on perf_clr=1 (perf_clr has priority over increment).
- Undefined: counters are absent, stall_cnt and flush_cnt are tied to 0, and perf_clr is ignored.

Test Plan:
- Reset then independent ALU ops (no matches) -> state=0, pc_en=1, dex_bubble=0 every cycle; hazard_err=0.
- DOF aa=3, use_a=1; EX ex_da=3, ex_rw=1, RF_WT=0 -> 2 stall cycles (EX then WB), pc_en=0, dex_bubble=1, state=1; then RUN.
- aa=0, ex_da=0, ex_rw=1, R0_ZERO=1 -> no stall.
- br_taken=1 concurrent with haz=1 -> ifd_flush=1, dex_bubble=1, pc_en=1, state=2 for 1 cycle, then 0; flush_cnt=1, stall_cnt=0.
- ext_hold=1 for 4 cycles during STALL -> all enables 0, state=3, stall timer frozen; release -> STALL resumes.
- Forced haz for 16 cycles, MAX_STALL=15 -> hazard_err=1 at cycle 16 and stays 1 after the hazard clears; rst=0 mid-stall -> state=0, hazard_err=0.
